// File: rtl/axi_inst_sram_pkg.sv
// +------------------------------------------------------------------+
// | axi_inst_sram_pkg : shared constants and FSM type for inst SRAM   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package axi_inst_sram_pkg;

  localparam logic [31:0] RST_PC          = 32'h8000_0000;
  localparam logic [2:0]  AXI_RESP_OKAY   = 3'b000;
  localparam logic [2:0]  AXI_RESP_SLVERR = 3'b010;
  localparam logic [2:0]  AXI_RESP_DECERR = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/axi_inst_sram_lfsr8.sv
// +------------------------------------------------------------------+
// | lfsr8 : 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, seed 8'h01       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= 8'h01;
    else if (en)
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

`default_nettype wire

// File: rtl/axi_inst_sram.sv
// +------------------------------------------------------------------+
// | axi_inst_sram : read-only AXI-style instruction memory slave       |
// | Option macro: AXI_INST_SRAM_RANDOM_DELAY_EN (LFSR response delay)  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module axi_inst_sram
  import axi_inst_sram_pkg::*;
#(
  parameter int                DATA_LEN    = 32,
  parameter int                MEM_DEPTH   = 4096,
  parameter logic [DATA_LEN-1:0] BASE_ADDR = RST_PC,
  parameter int                FIXED_DELAY = 0,
  parameter int                DELAY_BITS  = 3,
  parameter                    INIT_FILE   = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arvalid,
  output logic                arready,
  input  logic [DATA_LEN-1:0] araddr,
  output logic [DATA_LEN-1:0] rdata,
  output logic                rvalid,
  output logic [2:0]          rresp,
  input  logic                rready
);

  localparam int IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int FIX_W   = (FIXED_DELAY > 0) ? $clog2(FIXED_DELAY + 1) : 1;
  localparam int CNT_W   = (DELAY_BITS > FIX_W) ? DELAY_BITS : FIX_W;

  logic [DATA_LEN-1:0] mem [0:MEM_DEPTH-1];

  state_t              state;
  logic [DATA_LEN-1:0] addr_q;
  logic [CNT_W-1:0]    cnt;
  logic [7:0]          lfsr_q;
  logic [CNT_W-1:0]    delay;
  logic                accept;
  logic [DATA_LEN-1:0] sel_addr;
  logic [DATA_LEN:0]   hi_bound;
  logic [IDX_W-1:0]    word_idx;
  logic [DATA_LEN-1:0] ld_data;
  logic [2:0]          ld_resp;
  logic                unused_lfsr;

  assign accept = (state == ST_IDLE) && arvalid && arready;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .q     (lfsr_q)
  );

`ifdef AXI_INST_SRAM_RANDOM_DELAY_EN
  assign delay = CNT_W'(lfsr_q[DELAY_BITS-1:0]);
`else
  assign delay = CNT_W'(FIXED_DELAY);
`endif
  assign unused_lfsr = ^lfsr_q;

  // Zero-delay reads load the response in the accept cycle, before addr_q is valid.
  assign sel_addr = (state == ST_IDLE) ? araddr : addr_q;
  assign hi_bound = {1'b0, BASE_ADDR} + (DATA_LEN+1)'(4 * MEM_DEPTH);
  assign word_idx = IDX_W'((sel_addr - BASE_ADDR) >> 2);

  always_comb begin
    ld_resp = AXI_RESP_OKAY;
    ld_data = '0;
    if (sel_addr[1:0] != 2'b00)
      ld_resp = AXI_RESP_SLVERR;
    else if (({1'b0, sel_addr} < {1'b0, BASE_ADDR}) || ({1'b0, sel_addr} >= hi_bound))
      ld_resp = AXI_RESP_DECERR;
    else
      ld_data = mem[word_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= AXI_RESP_OKAY;
      addr_q  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          arready <= 1'b1;
          if (accept) begin
            addr_q  <= araddr;
            arready <= 1'b0;
            if (delay == '0) begin
              state  <= ST_RESP;
              rvalid <= 1'b1;
              rdata  <= ld_data;
              rresp  <= ld_resp;
            end else begin
              cnt   <= delay - CNT_W'(1);
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state  <= ST_RESP;
            rvalid <= 1'b1;
            rdata  <= ld_data;
            rresp  <= ld_resp;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rready) begin
            rvalid  <= 1'b0;
            arready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          arready <= 1'b0;
          rvalid  <= 1'b0;
          rdata   <= '0;
          rresp   <= AXI_RESP_OKAY;
          addr_q  <= '0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_inst_sram.sv
// +------------------------------------------------------------------+
// | tb_axi_inst_sram : scoreboard bench for axi_inst_sram             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_axi_inst_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          BUDGET = 50;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  resp;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] araddr  [2];
  logic [31:0] rdata   [2];
  logic        rvalid  [2];
  logic [2:0]  rresp   [2];
  logic        rready  [2];

  int          vectors;
  int          errors;
  int          cyc;
  exp_t        sb [$];
  logic [31:0] model_mem [16];
  logic [31:0] last_word;
  logic [7:0]  model_lfsr [2];
  int          fixed_d [2];

  axi_inst_sram #(.FIXED_DELAY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .arvalid(arvalid[0]), .arready(arready[0]),
    .araddr(araddr[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .rresp(rresp[0]),
    .rready(rready[0])
  );

  axi_inst_sram #(.FIXED_DELAY(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .arvalid(arvalid[1]), .arready(arready[1]),
    .araddr(araddr[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .rresp(rresp[1]),
    .rready(rready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // arready and rvalid must never overlap on either slave.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++)
        check("no_overlap", {31'd0, arready[k] && rvalid[k]}, 32'd0);
    end
  end

  function automatic exp_t model_decode(input logic [31:0] a);
    exp_t        e;
    logic [31:0] idx;
    e.data = 32'd0;
    e.resp = 3'b000;
    e.lat  = 0;
    if (a[1:0] != 2'b00) begin
      e.resp = 3'b010;
    end else if (a < BASE || a >= BASE + 32'h4000) begin
      e.resp = 3'b011;
    end else begin
      idx = (a - BASE) >> 2;
      if (idx < 16) e.data = model_mem[idx];
      else          e.data = last_word;
    end
    return e;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  task automatic do_read(input int d, input logic [31:0] addr, input int stall, input string tag);
    int          n;
    int          guard;
    exp_t        e;
    exp_t        got;
    logic [31:0] held;
    @(negedge clk);
    arvalid[d] = 1'b1;
    araddr[d]  = addr;
    rready[d]  = (stall == 0);
    guard = 0;
    while (!arready[d] && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    if (!arready[d]) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
      arvalid[d] = 1'b0;
      rready[d]  = 1'b1;
      return;
    end
    n = cyc;
    e = model_decode(addr);
`ifdef AXI_INST_SRAM_RANDOM_DELAY_EN
    e.lat = 1 + int'(model_lfsr[d][2:0]);
`else
    e.lat = 1 + fixed_d[d];
`endif
    model_lfsr[d] = lfsr_step(model_lfsr[d]);
    sb.push_back(e);
    @(negedge clk);
    arvalid[d] = 1'b0;
    araddr[d]  = 32'hDEAD_BEEF;
    guard = 0;
    while (!rvalid[d] && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    if (!rvalid[d]) begin
      check({tag, "_rvalid_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
      rready[d] = 1'b1;
      return;
    end
    got = sb.pop_front();
    check({tag, "_latency"}, 32'(cyc - n), 32'(got.lat));
    check({tag, "_rdata"}, rdata[d], got.data);
    check({tag, "_rresp"}, {29'd0, rresp[d]}, {29'd0, got.resp});
    held = rdata[d];
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_rvalid"}, {31'd0, rvalid[d]}, 32'd1);
      check({tag, "_stall_rdata"}, rdata[d], held);
    end
    rready[d] = 1'b1;
    @(negedge clk);
    check({tag, "_rvalid_drop"}, {31'd0, rvalid[d]}, 32'd0);
    check({tag, "_arready_back"}, {31'd0, arready[d]}, 32'd1);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    fixed_d[0] = 0;
    fixed_d[1] = 3;
    model_lfsr[0] = 8'h01;
    model_lfsr[1] = 8'h01;
    for (int i = 0; i < 16; i++)
      model_mem[i] = (i == 0) ? 32'h0000_0413 : $urandom;
    last_word = 32'hCAFE_F00D;
    for (int i = 0; i < 16; i++) begin
      dut0.mem[i] = model_mem[i];
      dut1.mem[i] = model_mem[i];
    end
    dut0.mem[4095] = last_word;
    dut1.mem[4095] = last_word;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      arvalid[k] = 1'b0;
      araddr[k]  = 32'd0;
      rready[k]  = 1'b1;
    end

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_arready", {31'd0, arready[k]}, 32'd0);
      check("rst_rvalid", {31'd0, rvalid[k]}, 32'd0);
      check("rst_rdata", rdata[k], 32'd0);
      check("rst_rresp", {29'd0, rresp[k]}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_arready0", {31'd0, arready[0]}, 32'd1);

    do_read(0, 32'h8000_0000, 0, "first_word");
    do_read(1, 32'h8000_0004, 2, "stalled_delay3");
    do_read(0, 32'h8000_0002, 0, "misaligned");
    do_read(1, 32'h8000_0001, 0, "misaligned_d3");
    do_read(0, 32'h7FFF_FFFC, 1, "below_window");
    do_read(0, 32'h8000_4000, 0, "above_window");
    do_read(0, 32'hFFFF_FFFC, 0, "top_of_space");
    do_read(0, 32'h8000_3FFC, 0, "last_word");

    for (int i = 0; i < 5; i++) begin
      do_read(0, BASE + 32'(4 * (i + 4)), 0, "b2b_d0");
      do_read(1, BASE + 32'(4 * (i + 8)), 0, "b2b_d1");
    end

    // Reset while dut1 is counting down its response delay.
    @(negedge clk);
    arvalid[1] = 1'b1;
    araddr[1]  = 32'h8000_0004;
    begin
      int guard;
      guard = 0;
      while (!arready[1] && guard < BUDGET) begin
        @(negedge clk);
        guard++;
      end
    end
    @(negedge clk);
    arvalid[1] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_arready", {31'd0, arready[1]}, 32'd0);
    check("midrst_rvalid", {31'd0, rvalid[1]}, 32'd0);
    sb.delete();
    model_lfsr[0] = 8'h01;
    model_lfsr[1] = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_arready", {31'd0, arready[1]}, 32'd1);
    do_read(1, 32'h8000_0008, 0, "after_reset");

    for (int i = 0; i < 4; i++)
      do_read(0, BASE + 32'(4 * i), 0, "fetch_seq");

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
